// File: rtl/instr_decoder.sv
// Instruction decoder: turns 40-bit words into unit/func micro-ops and expands vector opcodes
// into VLEN elements. Define INSTR_DECODER_ILLEGAL_CNT_EN to add the illegal_count output.
module instr_decoder #(
  parameter int unsigned VLEN       = 4,
  parameter int unsigned DST_STRIDE = 1,
  parameter int unsigned ELEM_W     = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [39:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_unit,
  output logic [3:0]        out_func,
  output logic [31:0]       out_dst,
  output logic              out_vector,
  output logic [ELEM_W-1:0] out_elem,
  output logic              out_last,
  output logic              illegal
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
  ,
  output logic [15:0]       illegal_count
`endif
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  localparam logic [1:0] UnitArith = 2'd0;
  localparam logic [1:0] UnitLogic = 2'd1;
  localparam logic [1:0] UnitSfu   = 2'd2;
  localparam logic [ELEM_W-1:0] ElemLast = ELEM_W'(VLEN - 1);

  state_e             state_q, state_d;
  logic [1:0]         unit_q, unit_d;
  logic [3:0]         func_q, func_d;
  logic [31:0]        dst_q, dst_d;
  logic               vector_q, vector_d;
  logic [ELEM_W-1:0]  elem_q, elem_d, elem_inc;
  logic               last_q, last_d;
  logic               illegal_q, illegal_d;

  logic [7:0]         op;
  logic               dec_legal;
  logic [1:0]         dec_unit;
  logic [3:0]         dec_func;
  logic               dec_vector;
  logic               accept;

  assign op = in_instr[39:32];

  always_comb begin
    dec_legal  = 1'b1;
    dec_unit   = UnitArith;
    dec_func   = 4'd0;
    dec_vector = 1'b0;
    if (op <= 8'd3) begin
      dec_func = op[3:0];
    end else if (op <= 8'd7) begin
      dec_unit = UnitLogic;
      dec_func = 4'(op - 8'd4);
    end else if (op <= 8'd16) begin
      dec_unit = UnitSfu;
      dec_func = 4'(op - 8'd8);
    end else if (op <= 8'd20) begin
      dec_func   = 4'(op - 8'd17);
      dec_vector = 1'b1;
    end else begin
      dec_legal = 1'b0;
    end
  end

  // A new word may slip in on the same cycle the final micro-op is taken.
  assign in_ready = (state_q == StIdle) || ((state_q == StIssue) && out_ready && last_q);
  assign accept   = in_valid && in_ready;
  assign elem_inc = elem_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    func_d    = func_q;
    dst_d     = dst_q;
    vector_d  = vector_q;
    elem_d    = elem_q;
    last_d    = last_q;
    illegal_d = 1'b0;
    if (accept) begin
      if (dec_legal) begin
        state_d  = StIssue;
        unit_d   = dec_unit;
        func_d   = dec_func;
        dst_d    = in_instr[31:0];
        vector_d = dec_vector;
        elem_d   = '0;
        last_d   = !dec_vector || (VLEN == 1);
      end else begin
        state_d   = StIdle;
        illegal_d = 1'b1;
      end
    end else if ((state_q == StIssue) && out_ready) begin
      if (last_q) begin
        state_d = StIdle;
      end else begin
        elem_d = elem_inc;
        dst_d  = dst_q + DST_STRIDE;
        last_d = (elem_inc == ElemLast);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      unit_q    <= '0;
      func_q    <= '0;
      dst_q     <= '0;
      vector_q  <= 1'b0;
      elem_q    <= '0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      func_q    <= func_d;
      dst_q     <= dst_d;
      vector_q  <= vector_d;
      elem_q    <= elem_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = (state_q == StIssue);
  assign out_unit   = unit_q;
  assign out_func   = func_q;
  assign out_dst    = dst_q;
  assign out_vector = vector_q;
  assign out_elem   = elem_q;
  assign out_last   = last_q;
  assign illegal    = illegal_q;

`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
  logic [15:0] cnt_q;

  // Counts alongside the illegal pulse so both are visible in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (illegal_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign illegal_count = cnt_q;
`endif

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Consumer side of the instruction encoding: accepts 40-bit instruction words (opcode[39:32], dst[31:0]) over valid/ready and emits decoded micro-ops to execution units.
- Scalar opcodes become one micro-op each; vector opcodes are expanded into VLEN per-element micro-ops with stepped destination addresses.
- Sits between instruction fetch and the ALU/logic/SFU dispatch stage; flags illegal opcodes.

Parameters:
- VLEN, 4, element micro-ops per vector instruction (>=1).
- DST_STRIDE, 1, dst increment between vector elements (32-bit).
- ELEM_W, max(1,$clog2(VLEN)), width of element index (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  decoder can accept a word
- in_instr  in  40  [39:32] opcode, [31:0] dst
- out_valid  out  1  micro-op valid
- out_ready  in  1  downstream accepts micro-op
- out_unit  out  2  0=ARITH, 1=LOGIC, 2=SFU (3 never driven)
- out_func  out  4  function within unit
- out_dst  out  32  destination for this micro-op
- out_vector  out  1  micro-op belongs to a vector instruction
- out_elem  out  ELEM_W  element index (0 for scalar)
- out_last  out  1  final micro-op of the instruction
- illegal  out  1  one-cycle pulse: illegal opcode consumed

Behaviour:
- Reset (async, rst_n low): state IDLE, out_valid=0, out_unit/func/dst/elem=0, out_vector=0, out_last=0, illegal=0. Any in-flight vector sequence is abandoned; out_valid drops immediately.
- Opcode decode:
  - 0-3 (s_add..s_div): ARITH, func=op.
  - 4-7 (s_and..s_not): LOGIC, func=op-4.
  - 8-16 (s_abs..s_max): SFU, func=op-8.
  - 17-20 (v_add..v_div): ARITH, func=op-17, vector.
  - 21-255: illegal.
- States: IDLE, ISSUE.
- Input handshake:
  - in_ready = (state==IDLE) || (state==ISSUE && out_ready && out_last).
  - Combinational out_ready->in_ready path is permitted; it allows one scalar per cycle.
  - Transfer occurs when in_valid && in_ready.
- Legal word accepted:
  - Next cycle: state ISSUE, out_valid=1, out_elem=0, out_dst=dst.
  - out_last=1 for scalars or when VLEN==1.
  - Latency is 1 cycle from input handshake to out_valid.
- Illegal word accepted:
  - Word consumed, no micro-op produced.
  - Next cycle: illegal=1 for exactly one cycle; state IDLE, or out_valid=0 if it arrived on a last-handshake.
- ISSUE with out_valid && !out_ready: all out_* held stable.
- ISSUE with out_valid && out_ready && !out_last (vector): next cycle out_elem+1, out_dst += DST_STRIDE (mod 2^32 wrap), out_last=(out_elem+1==VLEN-1).
- ISSUE with out_valid && out_ready && out_last:
  - New word accepted this cycle: load it (or pulse illegal).
  - Otherwise: state IDLE, out_valid=0.
- in_instr is ignored whenever in_ready=0.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: INSTR_DECODER_ILLEGAL_CNT_EN.
- With macro:
  - Extra output port illegal_count [15:0]. Reset 0.
  - Increments by 1 in the cycle illegal pulses; saturates at 0xFFFF.
- Without macro: port and counter absent; all other behaviour identical.

Test Plan:
- Scalar add: in_instr=0x00_00000010, out_ready=1 -> next cycle out_valid=1, unit=0, func=0, dst=0x10, vector=0, elem=0, last=1; in_ready stays 1.
- SFU max under backpressure: 0x10_00000ABC, out_ready=0 for 3 cycles -> unit=2, func=8, dst=0xABC held stable 3 cycles; handshake on 4th; in_ready=0 while stalled.
- Vector wrap: VLEN=4, stride=1, 0x13_FFFFFFFE -> 4 micro-ops, unit=0, func=2, dst=FFFFFFFE, FFFFFFFF, 00000000, 00000001, elem 0..3, last only on 4th; in_ready=0 until 4th handshake.
- Illegal then legal back-to-back: 0x15_00000000 then 0x05_00000020 -> illegal pulses 1 cycle with no micro-op; then unit=1, func=1, dst=0x20; illegal_count=1 with macro.
- Back-to-back scalars: 8 consecutive 0x01_0000000N words, in_valid and out_ready held high -> 8 micro-ops on 8 consecutive cycles, dst 0..7, no bubbles.
- Reset mid-vector: assert rst_n=0 after 2nd element of v_add -> out_valid=0 immediately; after release, state IDLE, in_ready=1, no residual elements issued.
